// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and cursor types
package vga_pkg;

    // 640x480@60 timing, shared with vga_interface
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CURSOR_SIZE_DEF = 16;

    typedef enum logic {
        CUR_SOLID,
        CUR_INVERT
    } cursor_mode_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } cursor_pos_t;

endpackage

// File: rtl/cursor_mask_regs.sv
// rtl/cursor_mask_regs.sv - cursor bitmap flop array, one synchronous write row, one async read row
module cursor_mask_regs
    import vga_pkg::*;
#(
    parameter int SIZE = CURSOR_SIZE_DEF
) (
    input  logic                    vga_clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [$clog2(SIZE)-1:0] wr_addr,
    input  logic [SIZE-1:0]         wr_row,
    input  logic [$clog2(SIZE)-1:0] rd_addr,
    output logic [SIZE-1:0]         rd_row
);

    logic [SIZE-1:0] rows [SIZE];

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                rows[i] <= '0;
            end
        end else if (wr) begin
            rows[wr_addr] <= wr_row;
        end
    end

    assign rd_row = rows[rd_addr];

endmodule

// File: rtl/vga_cursor_overlay.sv
// rtl/vga_cursor_overlay.sv - composites a hardware cursor onto the pixel stream with frame-synchronous position update
module vga_cursor_overlay
    import vga_pkg::*;
#(
    parameter int         CURSOR_SIZE   = CURSOR_SIZE_DEF,
    parameter logic [7:0] CURSOR_COLOR  = 8'hFF,
    parameter string      CURSOR_MODE   = "SOLID",
    parameter int         H_VISIBLE_END = 639,
    parameter int         V_VISIBLE_END = 479
) (
    input  logic                           vga_clk,
    input  logic                           rst_n,
    input  logic [7:0]                     pix_in,
    input  logic                           hs_in,
    input  logic                           vs_in,
    input  logic                           blank_n_in,
    input  logic [9:0]                     p_count,
    input  logic [9:0]                     l_count,
    input  logic [9:0]                     cur_x,
    input  logic [9:0]                     cur_y,
    input  logic                           cur_en,
    input  logic                           cur_valid,
    output logic                           cur_ready,
    input  logic                           spr_wr,
    input  logic [$clog2(CURSOR_SIZE)-1:0] spr_addr,
    input  logic [CURSOR_SIZE-1:0]         spr_row,
    output logic [7:0]                     pix_out,
    output logic                           hs_out,
    output logic                           vs_out,
    output logic                           blank_n_out,
    output logic                           frame_start
);

    localparam int           AW           = $clog2(CURSOR_SIZE);
    localparam cursor_mode_t MODE         = (CURSOR_MODE == "INVERT") ? CUR_INVERT : CUR_SOLID;
    localparam logic [9:0]   H_END        = 10'(H_VISIBLE_END);
    localparam logic [9:0]   V_END        = 10'(V_VISIBLE_END);
    localparam logic [9:0]   FIRST_VBLANK = 10'(V_VISIBLE_END + 1);
    localparam logic [9:0]   SIZE10       = 10'(CURSOR_SIZE);

    cursor_pos_t act;
    cursor_pos_t pend;
    cursor_pos_t req;
    logic        pending_full;
    logic        accept;
    logic        boundary;

    assign req       = '{x: cur_x, y: cur_y, en: cur_en};
    assign cur_ready = ~pending_full;
    assign accept    = cur_valid & ~pending_full;
    assign boundary  = (p_count == 10'd0) & (l_count == FIRST_VBLANK);

    // Position changes land only on the first blanking line so a frame never shows two cursors.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            act          <= '0;
            pend         <= '0;
            pending_full <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (boundary && pending_full) begin
                act          <= pend;
                pending_full <= 1'b0;
                frame_start  <= 1'b1;
            end else if (boundary && accept) begin
                act         <= req;
                frame_start <= 1'b1;
            end else if (accept) begin
                pend         <= req;
                pending_full <= 1'b1;
            end
        end
    end

    logic [9:0]             dx;
    logic [9:0]             dy;
    logic                   hit;
    logic [CURSOR_SIZE-1:0] mask_row;

    // Offsets left of / above the cursor wrap to large values and fall outside the box.
    assign dx  = p_count - act.x;
    assign dy  = l_count - act.y;
    assign hit = act.en & blank_n_in & (p_count <= H_END) & (l_count <= V_END)
               & (dx < SIZE10) & (dy < SIZE10);

    cursor_mask_regs #(
        .SIZE(CURSOR_SIZE)
    ) u_mask (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .wr      (spr_wr),
        .wr_addr (spr_addr),
        .wr_row  (spr_row),
        .rd_addr (dy[AW-1:0]),
        .rd_row  (mask_row)
    );

    logic                   s1_hit;
    logic [AW-1:0]          s1_dx;
    logic [CURSOR_SIZE-1:0] s1_row;
    logic [7:0]             s1_pix;
    logic                   s1_hs;
    logic                   s1_vs;
    logic                   s1_blank_n;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit     <= 1'b0;
            s1_dx      <= '0;
            s1_row     <= '0;
            s1_pix     <= '0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_blank_n <= 1'b0;
        end else begin
            s1_hit     <= hit;
            s1_dx      <= dx[AW-1:0];
            s1_row     <= mask_row;
            s1_pix     <= pix_in;
            s1_hs      <= hs_in;
            s1_vs      <= vs_in;
            s1_blank_n <= blank_n_in;
        end
    end

    logic       sel;
    logic [7:0] pix_next;

    always_comb begin
        sel      = s1_hit & s1_row[s1_dx];
        pix_next = s1_pix;
        if (!s1_blank_n) begin
            pix_next = 8'h00;
        end else if (sel) begin
            pix_next = (MODE == CUR_SOLID) ? CURSOR_COLOR : ~s1_pix;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out     <= 8'h00;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
            blank_n_out <= 1'b0;
        end else begin
            pix_out     <= pix_next;
            hs_out      <= s1_hs;
            vs_out      <= s1_vs;
            blank_n_out <= s1_blank_n;
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// tb/tb_vga_cursor_overlay.sv - self-checking bench for vga_cursor_overlay (SOLID and INVERT instances)
module tb_vga_cursor_overlay;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        hs_in, vs_in, blank_n_in;
    logic [9:0]  p_count, l_count, cur_x, cur_y;
    logic        cur_en, cur_valid, spr_wr;
    logic [3:0]  spr_addr;
    logic [15:0] spr_row;

    logic [7:0]  pix_out, pix_out_i;
    logic        cur_ready, hs_out, vs_out, blank_n_out, frame_start;
    logic        cur_ready_i, hs_out_i, vs_out_i, blank_n_out_i, frame_start_i;

    always #5 vga_clk = ~vga_clk;

    vga_cursor_overlay #(.CURSOR_MODE("SOLID")) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_in(pix_in), .hs_in(hs_in), .vs_in(vs_in),
        .blank_n_in(blank_n_in), .p_count(p_count), .l_count(l_count), .cur_x(cur_x),
        .cur_y(cur_y), .cur_en(cur_en), .cur_valid(cur_valid), .cur_ready(cur_ready),
        .spr_wr(spr_wr), .spr_addr(spr_addr), .spr_row(spr_row), .pix_out(pix_out),
        .hs_out(hs_out), .vs_out(vs_out), .blank_n_out(blank_n_out), .frame_start(frame_start)
    );

    vga_cursor_overlay #(.CURSOR_MODE("INVERT")) dut_inv (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_in(pix_in), .hs_in(hs_in), .vs_in(vs_in),
        .blank_n_in(blank_n_in), .p_count(p_count), .l_count(l_count), .cur_x(cur_x),
        .cur_y(cur_y), .cur_en(cur_en), .cur_valid(cur_valid), .cur_ready(cur_ready_i),
        .spr_wr(spr_wr), .spr_addr(spr_addr), .spr_row(spr_row), .pix_out(pix_out_i),
        .hs_out(hs_out_i), .vs_out(vs_out_i), .blank_n_out(blank_n_out_i), .frame_start(frame_start_i)
    );

    int checks = 0;
    int errors = 0;

    // reference state: active cursor, pending request, bitmap
    int          m_x, m_y, p_x, p_y;
    bit          m_en, p_en, m_full, m_fs;
    logic [15:0] m_mask [16];

    typedef struct {
        logic [7:0] ps;
        logic [7:0] pi;
        bit         hs;
        bit         vs;
        bit         bl;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int         p;
        int         l;
        logic [7:0] pix;
        logic [7:0] exp_s;
        logic [7:0] exp_i;
    } vec_t;
    vec_t t2[10];
    vec_t t3[5];

    bit         use_tbl = 0;
    logic [7:0] tbl_s, tbl_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [7:0] ref_pix(input int p, input int l, input logic [7:0] pix,
                                           input bit vis, input bit inv);
        if (!vis) return 8'h00;
        if (m_en && p >= m_x && p < m_x + 16 && l >= m_y && l < m_y + 16 && m_mask[l - m_y][p - m_x])
            return inv ? ~pix : 8'hFF;
        return pix;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_en = 0; p_x = 0; p_y = 0; p_en = 0; m_full = 0; m_fs = 0;
        for (int i = 0; i < 16; i++) m_mask[i] = '0;
        q.delete();
        q.push_back('{8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic step(input int p, input int l, input logic [7:0] pix, input bit hs, input bit vs);
        exp_t e;
        bit   vis, acc, bnd;
        vis        = (p <= 639) && (l <= 479);
        p_count    = 10'(p);
        l_count    = 10'(l);
        pix_in     = pix;
        hs_in      = hs;
        vs_in      = vs;
        blank_n_in = vis;
        e.ps = use_tbl ? tbl_s : ref_pix(p, l, pix, vis, 0);
        e.pi = use_tbl ? tbl_i : ref_pix(p, l, pix, vis, 1);
        e.hs = hs; e.vs = vs; e.bl = vis;
        q.push_back(e);
        bnd = (p == 0) && (l == 480);
        acc = cur_valid && !m_full;
        @(posedge vga_clk);
        m_fs = 0;
        if (bnd && m_full) begin
            m_x = p_x; m_y = p_y; m_en = p_en; m_full = 0; m_fs = 1;
        end else if (bnd && acc) begin
            m_x = int'(cur_x); m_y = int'(cur_y); m_en = cur_en; m_fs = 1;
        end else if (acc) begin
            p_x = int'(cur_x); p_y = int'(cur_y); p_en = cur_en; m_full = 1;
        end
        if (spr_wr) m_mask[spr_addr] = spr_row;
        @(negedge vga_clk);
        e = q.pop_front();
        chk("pix_out", 32'(pix_out), 32'(e.ps));
        chk("pix_out_inv", 32'(pix_out_i), 32'(e.pi));
        chk("hs_out", 32'(hs_out), 32'(e.hs));
        chk("vs_out", 32'(vs_out), 32'(e.vs));
        chk("blank_n_out", 32'(blank_n_out), 32'(e.bl));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("cur_ready", 32'(cur_ready), 32'(!m_full));
        chk("frame_start_inv", 32'(frame_start_i), 32'(m_fs));
        if (acc) cur_valid = 1'b0;
    endtask

    task automatic rstep(input int p, input int l);
        step(p, l, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic scan(input int l, input int p0, input int p1, input logic [7:0] pix, input bit rnd);
        for (int p = p0; p <= p1; p++)
            step(p, l, rnd ? 8'($urandom) : pix, 1'($urandom), 1'($urandom));
    endtask

    task automatic write_row(input int a, input logic [15:0] r);
        spr_wr = 1'b1; spr_addr = 4'(a); spr_row = r;
        rstep(700, 500);
        spr_wr = 1'b0;
    endtask

    task automatic request(input int x, input int y, input bit en);
        cur_x = 10'(x); cur_y = 10'(y); cur_en = en; cur_valid = 1'b1;
    endtask

    initial begin
        t2[0] = '{99, 50, 8'h40, 8'h40, 8'h40};
        t2[1] = '{100, 50, 8'h40, 8'hFF, 8'hBF};
        t2[2] = '{115, 50, 8'h40, 8'hFF, 8'hBF};
        t2[3] = '{116, 50, 8'h40, 8'h40, 8'h40};
        t2[4] = '{100, 49, 8'h40, 8'h40, 8'h40};
        t2[5] = '{100, 65, 8'h40, 8'hFF, 8'hBF};
        t2[6] = '{100, 66, 8'h40, 8'h40, 8'h40};
        t2[7] = '{107, 58, 8'h40, 8'hFF, 8'hBF};
        t2[8] = '{115, 65, 8'h40, 8'hFF, 8'hBF};
        t2[9] = '{700, 50, 8'h40, 8'h00, 8'h00};
        t3[0] = '{100, 50, 8'h0F, 8'hFF, 8'hF0};
        t3[1] = '{101, 50, 8'h0F, 8'h0F, 8'h0F};
        t3[2] = '{100, 51, 8'h0F, 8'h0F, 8'h0F};
        t3[3] = '{99, 50, 8'h0F, 8'h0F, 8'h0F};
        t3[4] = '{115, 65, 8'h0F, 8'h0F, 8'h0F};

        pix_in = 0; hs_in = 1; vs_in = 1; blank_n_in = 0; p_count = 0; l_count = 0;
        cur_x = 0; cur_y = 0; cur_en = 0; cur_valid = 0; spr_wr = 0; spr_addr = 0; spr_row = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge vga_clk);
        chk("reset pix_out", 32'(pix_out), 32'h00);
        chk("reset hs_out", 32'(hs_out), 32'h1);
        chk("reset vs_out", 32'(vs_out), 32'h1);
        chk("reset blank_n_out", 32'(blank_n_out), 32'h0);
        chk("reset frame_start", 32'(frame_start), 32'h0);
        chk("reset cur_ready", 32'(cur_ready), 32'h1);
        rst_n = 1'b1;
        model_reset();

        // cursor disabled: pass-through and blanking
        scan(10, 630, 645, 8'h40, 0);
        scan(479, 0, 3, 8'h40, 0);
        scan(480, 0, 3, 8'h40, 0);

        // full mask, request mid-frame, commit only at the boundary
        for (int i = 0; i < 16; i++) write_row(i, 16'hFFFF);
        request(100, 50, 1);
        rstep(5, 200);
        chk("t2 ready dropped", 32'(cur_ready), 32'h0);
        scan(50, 98, 118, 8'h40, 0);
        rstep(799, 479);
        rstep(0, 480);
        chk("t2 frame_start", 32'(frame_start), 32'h1);
        use_tbl = 1;
        for (int i = 0; i < 10; i++) begin
            tbl_s = t2[i].exp_s; tbl_i = t2[i].exp_i;
            step(t2[i].p, t2[i].l, t2[i].pix, 1'($urandom), 1'($urandom));
        end
        use_tbl = 0;
        step(0, 0, 8'h40, 1, 1);
        step(0, 0, 8'h40, 1, 1);
        scan(57, 95, 120, 8'h00, 1);

        // single-pixel bitmap
        write_row(0, 16'h0001);
        for (int i = 1; i < 16; i++) write_row(i, 16'h0000);
        use_tbl = 1;
        for (int i = 0; i < 5; i++) begin
            tbl_s = t3[i].exp_s; tbl_i = t3[i].exp_i;
            step(t3[i].p, t3[i].l, t3[i].pix, 1'($urandom), 1'($urandom));
        end
        use_tbl = 0;

        // right/bottom edge clipping
        for (int i = 0; i < 16; i++) write_row(i, 16'hFFFF);
        request(632, 472, 1);
        rstep(5, 300);
        rstep(0, 480);
        for (int l = 470; l <= 481; l++) scan(l, 628, 645, 8'h00, 1);
        for (int l = 0; l <= 8; l++) scan(l, 0, 10, 8'h00, 1);

        // held request across the boundary, then boundary bypass
        request(200, 100, 1);
        rstep(5, 300);
        request(300, 200, 1);
        rstep(6, 300);
        rstep(7, 300);
        rstep(0, 480);
        chk("t5 commit frame_start", 32'(frame_start), 32'h1);
        chk("t5 ready after commit", 32'(cur_ready), 32'h1);
        rstep(1, 480);
        chk("t5 second accepted", 32'(cur_ready), 32'h0);
        chk("t5 valid consumed", 32'(cur_valid), 32'h0);
        scan(100, 195, 220, 8'h00, 1);
        rstep(0, 480);
        scan(205, 295, 320, 8'h00, 1);
        request(400, 300, 1);
        rstep(0, 480);
        chk("t5 bypass frame_start", 32'(frame_start), 32'h1);
        chk("t5 bypass ready", 32'(cur_ready), 32'h1);
        scan(300, 395, 420, 8'h00, 1);

        // asynchronous reset with a request pending
        request(50, 60, 1);
        rstep(5, 300);
        for (int i = 0; i < 3; i++) step(10 + i, 10, 8'h55, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 pix_out", 32'(pix_out), 32'h00);
        chk("t6 hs_out", 32'(hs_out), 32'h1);
        chk("t6 vs_out", 32'(vs_out), 32'h1);
        chk("t6 blank_n_out", 32'(blank_n_out), 32'h0);
        chk("t6 frame_start", 32'(frame_start), 32'h0);
        chk("t6 cur_ready", 32'(cur_ready), 32'h1);
        @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) write_row(i, 16'hFFFF);
        rstep(0, 480);
        chk("t6 no stale commit", 32'(frame_start), 32'h0);
        scan(60, 45, 70, 8'h00, 1);

        // randomized frames against the reference model
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 4; k++) write_row($urandom_range(0, 15), 16'($urandom));
            if ($urandom_range(0, 3) != 0)
                request($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0);
            rstep(3, 250);
            for (int k = 0; k < 6; k++) begin
                int ty, tx, l, p0;
                ty = (k % 2 == 0 || !m_full) ? m_y : p_y;
                tx = (k % 2 == 0 || !m_full) ? m_x : p_x;
                l  = ty + $urandom_range(0, 18) - 1;
                if (l < 0) l = 0;
                p0 = tx - 2;
                if (p0 < 0) p0 = 0;
                scan(l, p0, p0 + 20, 8'h00, 1);
            end
            rstep(799, 479);
            rstep(0, 480);
            rstep(1, 480);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
